// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - captures a BCD digit scan stream and re-scans it onto a common-anode 4-digit display
module seg7_scan_driver #(
    parameter int DIGIT_CYCLES = 18,
    parameter int DEAD_CYCLES  = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] Bcd_in,
    input  logic [3:0] Sel_in,
    input  logic [2:0] Bright,
    input  logic       Lzb_en,
    output logic [6:0] Seg_out,
    output logic [3:0] Dig_out,
    output logic       Frame_done,
    output logic       Sel_err
);
    localparam int ON_LEN = DIGIT_CYCLES - DEAD_CYCLES;
    localparam int CW     = $clog2(DIGIT_CYCLES + 1);
    localparam logic [CW-1:0] SLOT_LAST = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] DEAD      = CW'(DEAD_CYCLES);

    typedef enum logic [1:0] {PH_BLANK, PH_LIT, PH_OFF} phase_t;

    logic [CW-1:0] slot_cnt;
    logic [CW-1:0] lit_len;
    logic [CW-1:0] lit_cur;
    logic [CW-1:0] lit_end;
    logic [1:0]    idx;
    logic [3:0]    cap  [4];
    logic [3:0]    disp [4];
    logic          cap_we;
    logic [1:0]    cap_idx;
    logic          sel_bad;
    logic          frame_edge;
    logic [3:0]    blank;
    phase_t        phase;
    logic [6:0]    seg_nxt;
    logic [3:0]    dig_nxt;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b0111111;
        endcase
    endfunction

    always_comb begin
        cap_we  = 1'b0;
        cap_idx = 2'd0;
        sel_bad = 1'b0;
        case (Sel_in)
            4'b1110: begin cap_we = 1'b1; cap_idx = 2'd0; end
            4'b1101: begin cap_we = 1'b1; cap_idx = 2'd1; end
            4'b1011: begin cap_we = 1'b1; cap_idx = 2'd2; end
            4'b0111: begin cap_we = 1'b1; cap_idx = 2'd3; end
            4'b1111: ;
            default: sel_bad = 1'b1;
        endcase
    end

    // Brightness is taken fresh at slot start so a mid-slot change never stretches the current digit
    always_comb begin
        lit_cur = (slot_cnt == '0) ? CW'((ON_LEN * (int'(Bright) + 1)) >> 3) : lit_len;
        lit_end = DEAD + lit_cur;
        if (slot_cnt < DEAD)
            phase = PH_BLANK;
        else if (slot_cnt < lit_end)
            phase = PH_LIT;
        else
            phase = PH_OFF;
    end

    always_comb begin
        blank[3] = Lzb_en && (disp[3] == 4'd0);
        blank[2] = blank[3] && (disp[2] == 4'd0);
        blank[1] = blank[2] && (disp[1] == 4'd0);
        blank[0] = 1'b0;
    end

    always_comb begin
        seg_nxt    = 7'b1111111;
        dig_nxt    = 4'b1111;
        frame_edge = (slot_cnt == SLOT_LAST) && (idx == 2'd3);
        if (phase == PH_LIT) begin
            dig_nxt = ~(4'b0001 << idx);
            if (!blank[idx])
                seg_nxt = seg_decode(disp[idx]);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            slot_cnt   <= '0;
            idx        <= 2'd0;
            lit_len    <= '0;
            Seg_out    <= 7'b1111111;
            Dig_out    <= 4'b1111;
            Frame_done <= 1'b0;
            Sel_err    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cap[i]  <= 4'd0;
                disp[i] <= 4'd0;
            end
        end else begin
            Seg_out    <= seg_nxt;
            Dig_out    <= dig_nxt;
            Frame_done <= frame_edge;
            Sel_err    <= sel_bad;
            // disp takes the pre-edge cap, so a write on this edge shows one frame later
            if (frame_edge) begin
                for (int i = 0; i < 4; i++)
                    disp[i] <= cap[i];
            end
            if (cap_we)
                cap[cap_idx] <= Bcd_in;
            if (slot_cnt == '0)
                lit_len <= lit_cur;
            if (slot_cnt == SLOT_LAST) begin
                slot_cnt <= '0;
                idx      <= idx + 2'd1;
            end else begin
                slot_cnt <= slot_cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;
    logic       Clk = 1'b0;
    logic       Reset;
    logic [3:0] Bcd_in;
    logic [3:0] Sel_in;
    logic [2:0] Bright;
    logic       Lzb_en;
    logic [6:0] Seg_out;
    logic [3:0] Dig_out;
    logic       Frame_done;
    logic       Sel_err;

    always #5 Clk = ~Clk;

    seg7_scan_driver dut (
        .Clk(Clk), .Reset(Reset), .Bcd_in(Bcd_in), .Sel_in(Sel_in),
        .Bright(Bright), .Lzb_en(Lzb_en), .Seg_out(Seg_out), .Dig_out(Dig_out),
        .Frame_done(Frame_done), .Sel_err(Sel_err)
    );

    typedef struct {
        logic [6:0] seg;
        logic [3:0] dig;
        logic       fd;
        logic       err;
        int         slot;
        int         idx;
    } exp_t;

    typedef struct packed {
        logic [15:0] d;
        logic        lzb;
        logic [27:0] e;
    } vec_t;

    localparam int NV = 8;
    vec_t tv [NV];
    exp_t sbq[$];

    int n_vec = 0;
    int n_bad = 0;
    int m_slot, m_idx, m_lit, cyc, first_fd;
    logic [3:0] m_cap  [4];
    logic [3:0] m_disp [4];
    logic [6:0] obs    [4];
    int         lit_cnt[4];

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'd0: seg_of = 7'h40;  4'd1: seg_of = 7'h79;
            4'd2: seg_of = 7'h24;  4'd3: seg_of = 7'h30;
            4'd4: seg_of = 7'h19;  4'd5: seg_of = 7'h12;
            4'd6: seg_of = 7'h02;  4'd7: seg_of = 7'h78;
            4'd8: seg_of = 7'h00;  4'd9: seg_of = 7'h10;
            default: seg_of = 7'h3F;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_slot = 0; m_idx = 0; m_lit = 0; cyc = 0; first_fd = -1;
        for (int i = 0; i < 4; i++) begin
            m_cap[i] = 4'd0;
            m_disp[i] = 4'd0;
        end
    endtask

    // Predict the edge's registered outputs, push, clock, then pop and compare
    task automatic step(input logic [3:0] bcd, input logic [3:0] sel);
        exp_t e;
        exp_t g;
        int lc;
        int wi;
        logic wr;
        logic [3:0] blk;
        Bcd_in = bcd;
        Sel_in = sel;
        lc = (m_slot == 0) ? 2 * (int'(Bright) + 1) : m_lit;
        blk[3] = Lzb_en && (m_disp[3] == 4'd0);
        blk[2] = blk[3] && (m_disp[2] == 4'd0);
        blk[1] = blk[2] && (m_disp[1] == 4'd0);
        blk[0] = 1'b0;
        e.seg = 7'h7F;
        e.dig = 4'hF;
        if (m_slot >= 2 && m_slot < 2 + lc) begin
            e.dig = ~(4'b0001 << m_idx);
            if (!blk[m_idx]) e.seg = seg_of(m_disp[m_idx]);
        end
        e.fd = (m_slot == 17 && m_idx == 3);
        wr = 1'b1;
        wi = 0;
        case (sel)
            4'b1110: wi = 0;
            4'b1101: wi = 1;
            4'b1011: wi = 2;
            4'b0111: wi = 3;
            default: wr = 1'b0;
        endcase
        e.err  = !wr && (sel != 4'b1111);
        e.slot = m_slot;
        e.idx  = m_idx;
        sbq.push_back(e);
        if (e.fd) for (int i = 0; i < 4; i++) m_disp[i] = m_cap[i];
        if (wr) m_cap[wi] = bcd;
        if (m_slot == 0) m_lit = lc;
        if (m_slot == 17) begin
            m_slot = 0;
            m_idx = (m_idx + 1) % 4;
        end else begin
            m_slot++;
        end
        @(posedge Clk);
        #1;
        g = sbq.pop_front();
        cyc++;
        check($sformatf("scan c%0d slot%0d dig%0d", cyc, g.slot, g.idx),
              {19'd0, Seg_out, Dig_out, Frame_done, Sel_err}, {19'd0, g.seg, g.dig, g.fd, g.err});
        if (g.slot == 10) obs[g.idx] = Seg_out;
        if (Dig_out != 4'hF) lit_cnt[g.idx]++;
        if (Frame_done && first_fd < 0) first_fd = cyc;
        @(negedge Clk);
    endtask

    // Always takes at least one step, then idles until the model reaches (s, i)
    task automatic run_to(input int s, input int i);
        int n;
        n = 0;
        do begin
            step(4'h0, 4'hF);
            n++;
        end while (!(m_slot == s && m_idx == i) && n < 200);
        if (!(m_slot == s && m_idx == i)) begin
            n_vec++;
            n_bad++;
            $display("FAIL run_to bound: slot %0d idx %0d not reached", s, i);
        end
    endtask

    initial begin
        tv[0] = '{d: 16'h0574, lzb: 1'b1, e: {7'h7F, 7'h12, 7'h78, 7'h19}};
        tv[1] = '{d: 16'h0574, lzb: 1'b0, e: {7'h40, 7'h12, 7'h78, 7'h19}};
        tv[2] = '{d: 16'h0000, lzb: 1'b1, e: {7'h7F, 7'h7F, 7'h7F, 7'h40}};
        tv[3] = '{d: 16'h3001, lzb: 1'b1, e: {7'h30, 7'h40, 7'h40, 7'h79}};
        tv[4] = '{d: 16'h0098, lzb: 1'b1, e: {7'h7F, 7'h7F, 7'h10, 7'h00}};
        tv[5] = '{d: 16'hFCBA, lzb: 1'b1, e: {7'h3F, 7'h3F, 7'h3F, 7'h3F}};
        tv[6] = '{d: 16'h0062, lzb: 1'b0, e: {7'h40, 7'h40, 7'h02, 7'h24}};
        tv[7] = '{d: 16'h0300, lzb: 1'b1, e: {7'h7F, 7'h30, 7'h40, 7'h40}};

        Reset = 1'b1; Bcd_in = 4'h0; Sel_in = 4'hF; Bright = 3'd7; Lzb_en = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) lit_cnt[i] = 0;
        #3;
        check("reset seg", Seg_out, 7'h7F);
        check("reset dig", Dig_out, 4'hF);
        check("reset frame_done", Frame_done, 1'b0);
        check("reset sel_err", Sel_err, 1'b0);
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;

        for (int k = 1; k <= 72; k++) begin
            step(4'h0, 4'hF);
            if (k == 2) check("dead c2 dig", Dig_out, 4'hF);
            if (k == 3) begin
                check("first lit dig", Dig_out, 4'hE);
                check("first lit seg", Seg_out, 7'h40);
            end
            if (k == 18) check("last lit dig", Dig_out, 4'hE);
            if (k == 19) check("slot1 dead dig", Dig_out, 4'hF);
        end
        check("first frame_done cycle", first_fd, 72);

        for (int t = 0; t < NV; t++) begin
            Lzb_en = tv[t].lzb;
            for (int d = 0; d < 4; d++) step(tv[t].d[4*d +: 4], ~(4'b0001 << d));
            run_to(0, 0);
            for (int d = 0; d < 4; d++) obs[d] = 7'h55;
            for (int k = 0; k < 72; k++) step(4'h0, 4'hF);
            for (int d = 0; d < 4; d++)
                check($sformatf("vec%0d digit%0d seg", t, d), obs[d], tv[t].e[7*d +: 7]);
        end

        Lzb_en = 1'b0;
        step(4'h9, 4'b1100);
        check("sel_err pulse", Sel_err, 1'b1);
        step(4'h9, 4'hF);
        check("sel_err idle", Sel_err, 1'b0);
        step(4'h3, 4'b0000);
        check("sel_err all-zero", Sel_err, 1'b1);
        run_to(0, 0);
        for (int k = 0; k < 72; k++) step(4'h0, 4'hF);
        check("illegal sel no write", obs[0], 7'h40);

        run_to(0, 0);
        step(4'h1, 4'b1110);
        run_to(17, 3);
        step(4'h6, 4'b1110);
        for (int k = 0; k < 72; k++) step(4'h0, 4'hF);
        check("boundary write old value", obs[0], 7'h79);
        for (int k = 0; k < 72; k++) step(4'h0, 4'hF);
        check("boundary write new value", obs[0], 7'h02);

        Bright = 3'd0;
        run_to(0, 0);
        for (int i = 0; i < 4; i++) lit_cnt[i] = 0;
        run_to(5, 1);
        Bright = 3'd3;
        run_to(0, 3);
        check("bright0 digit0 lit", lit_cnt[0], 2);
        check("bright mid-slot change", lit_cnt[1], 2);
        check("bright3 next slot lit", lit_cnt[2], 8);

        Bright = 3'd7;
        run_to(8, 1);
        check("pre-reset lit dig", Dig_out, 4'b1101);
        #2;
        Reset = 1'b1;
        #1;
        check("async reset seg", Seg_out, 7'h7F);
        check("async reset dig", Dig_out, 4'hF);
        model_reset();
        @(negedge Clk);
        Reset = 1'b0;
        for (int k = 1; k <= 150; k++) begin
            step(4'h0, 4'hF);
            if (k == 3) check("restart digit0 lit", Dig_out, 4'hE);
        end
        check("restart frame_done cycle", first_fd, 72);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Downstream display stage for the 4-digit scan/count block. Captures its time-multiplexed BCD digit stream (4-bit value plus active-low one-hot digit select) into a 4-entry capture buffer. Re-scans the digits at an LED-appropriate rate with anti-ghosting dead time, PWM brightness, leading-zero blanking and BCD-to-7-segment decoding. Drives the board's common-anode 4-digit display directly.

Parameters:
DIGIT_CYCLES, 18, clock cycles per digit slot (dead time + on window)
DEAD_CYCLES, 2, blanked cycles at the start of each slot; ON_LEN = DIGIT_CYCLES-DEAD_CYCLES must be a nonzero multiple of 8

Ports:
Clk  input  1  system clock
Reset  input  1  asynchronous, active-high reset
Bcd_in  input  4  digit value from the upstream scan block
Sel_in  input  4  upstream digit select, active-low one-hot; 1110 = digit0 (units) .. 0111 = digit3
Bright  input  3  brightness level 0..7
Lzb_en  input  1  leading-zero blanking enable
Seg_out  output  7  active-low segments {g,f,e,d,c,b,a}
Dig_out  output  4  active-low digit enables, same encoding as Sel_in
Frame_done  output  1  one-cycle pulse at each frame boundary
Sel_err  output  1  one-cycle pulse on an illegal Sel_in pattern

Behaviour:
- Reset (async, immediate, also mid-frame): Seg_out=1111111, Dig_out=1111, Frame_done=0, Sel_err=0, both buffers=0, digit index=0, slot_cnt=0.
- Capture: each posedge, if Sel_in has exactly one zero, cap[idx]<=Bcd_in. Sel_in=1111 is idle: no write, no error. Two or more zeros: no write; Sel_err=1 on the next cycle for one cycle.
- Double buffer: disp[0..3]<=cap[0..3] at the frame-boundary edge, i.e. when slot_cnt==DIGIT_CYCLES-1 and index==3. A capture write on that same edge lands in cap only and is displayed in the following frame (no tearing).
- Scan counter:
  - slot_cnt runs 0..DIGIT_CYCLES-1 and wraps.
  - index advances 0->1->2->3->0 on each wrap.
  - lit_len is sampled from Bright when slot_cnt==0: lit_len=(ON_LEN*(Bright+1))>>3. With defaults this is 2*(Bright+1), giving 2..16 cycles.
- Per-slot phases:
  - BLANK: slot_cnt<DEAD_CYCLES.
  - LIT: DEAD_CYCLES<=slot_cnt<DEAD_CYCLES+lit_len.
  - OFF: remainder of the slot.
  - BLANK and OFF drive Dig_out=1111 and Seg_out=1111111.
  - LIT drives Dig_out=~(1<<index) and Seg_out=decode(disp[index]), or 1111111 if the digit is blanked.
- Outputs are registered, so they reflect the counter state of the previous cycle (1-cycle latency). Frame_done is registered and high in the cycle after the frame-boundary edge.
- Decode (active-low gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Values 10..15 decode as dash 0111111.
- Leading-zero blanking (Lzb_en=1, evaluated on disp):
  - digit3 is blanked if disp[3]==0.
  - digit2 is blanked if disp[2]==0 and digit3 is blanked.
  - digit1 is blanked if disp[1]==0 and digit2 is blanked.
  - digit0 is never blanked.
  - With Lzb_en=0, no digit is blanked.
- Blanking and dead time never drive a digit enable low while segments change. Dig_out is 1111 on every slot transition cycle.
- Frame period = 4*DIGIT_CYCLES = 72 cycles by default.

Test Plan:
- Reset release, Lzb_en=0, Bright=7: cycles 0-1 all-off. Then Dig_out=1110, Seg_out=1000000 for 16 cycles. Pattern repeats for digits 1,2,3. First Frame_done pulse arrives 72 cycles after release.
- Feed Sel_in/Bcd_in = 1110/4, 1101/7, 1011/5, 0111/0, Lzb_en=1: after the next frame boundary, digit0=0011001, digit1=1111000, digit2=0010010, digit3 all-off (blanked). With Lzb_en=0, digit3=1000000.
- Bright=0: each digit is lit exactly 2 cycles after 2 dead cycles, then 14 off. Changing Bright to 3 mid-slot takes effect only at the next slot (8 lit cycles).
- Sel_in=1100 with Bcd_in=9: Sel_err pulses 1 cycle and no buffer changes. Sel_in=1111: no error, no write.
- Capture write to digit0 exactly on the frame-boundary edge: the old value shows for the next frame and the new value in the frame after.
- Reset asserted mid-LIT: Seg_out=1111111 and Dig_out=1111 immediately (async), buffers are cleared, and after release the scan restarts at digit0 BLANK.
